complex_mult_seq: RTL and testbench

- Sequential complex multiplier for the packed signed complex format used by the complex add/sub datapath: real part in [2W-1:W], imaginary part in [W-1:0], each a two's-complement integer.
- Operands enter through a valid/ready handshake; the product leaves through a second valid/ready handshake.
- One shared WxW signed multiplier is time-multiplexed over 4 steps.
- Results are saturated per component back to W bits, so outputs can feed complex add/sub directly.

---
 rtl/complex_mult_seq.sv | 146 ++++++++++++++
 tb/tb_complex_mult_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_mult_seq.sv
// Sequential signed complex multiplier, one shared WxW multiplier over 4 steps, per-component saturation.
// Latency: result registered 4 edges after acceptance; next acceptance possible 6 cycles after the last.
// Backpressure: result held in DONE until out_ready; in_ready stays low from acceptance to handoff.
module complex_mult_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] a,
    input  logic [2*W-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p,
    output logic           ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic signed [W-1:0]   r_ar;
    logic signed [W-1:0]   r_ai;
    logic signed [W-1:0]   r_br;
    logic signed [W-1:0]   r_bi;
    logic [1:0]            r_step;
    logic signed [2*W:0]   r_acc_r;
    logic signed [2*W:0]   r_acc_i;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [2*W-1:0]        r_p;
    logic                  r_ovf;

    logic signed [W-1:0]   w_mul_a;
    logic signed [W-1:0]   w_mul_b;
    logic signed [2*W-1:0] w_mul_a_x;
    logic signed [2*W-1:0] w_mul_b_x;
    logic signed [2*W-1:0] w_prod;
    logic signed [2*W:0]   w_prod_x;
    logic signed [2*W:0]   w_diff_r;
    logic signed [2*W:0]   w_sum_i;
    logic [W:0]            w_sat_r;
    logic [W:0]            w_sat_i;

    // Returns {saturated_flag, W-bit value}; fits when bits [2W:W-1] are all equal.
    function automatic logic [W:0] sat(input logic signed [2*W:0] v);
        logic [W:0] res;
        if ((v[2*W:W-1] == {(W+2){1'b0}}) || (v[2*W:W-1] == {(W+2){1'b1}})) begin
            res = {1'b0, v[W-1:0]};
        end else if (v[2*W]) begin
            res = {1'b1, 1'b1, {(W-1){1'b0}}};
        end else begin
            res = {1'b1, 1'b0, {(W-1){1'b1}}};
        end
        return res;
    endfunction

    always_comb begin
        w_mul_a = r_ar;
        w_mul_b = r_br;
        case (r_step)
            2'd0: begin w_mul_a = r_ar; w_mul_b = r_br; end
            2'd1: begin w_mul_a = r_ai; w_mul_b = r_bi; end
            2'd2: begin w_mul_a = r_ar; w_mul_b = r_bi; end
            default: begin w_mul_a = r_ai; w_mul_b = r_br; end
        endcase
    end

    // Sign-extend before multiplying so the 2W-bit product is exact.
    assign w_mul_a_x = {{W{w_mul_a[W-1]}}, w_mul_a};
    assign w_mul_b_x = {{W{w_mul_b[W-1]}}, w_mul_b};
    assign w_prod    = w_mul_a_x * w_mul_b_x;
    assign w_prod_x  = {w_prod[2*W-1], w_prod};
    assign w_diff_r  = r_acc_r - w_prod_x;
    assign w_sum_i   = r_acc_i + w_prod_x;
    assign w_sat_r   = sat(r_acc_r);
    assign w_sat_i   = sat(w_sum_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ar        <= '0;
            r_ai        <= '0;
            r_br        <= '0;
            r_bi        <= '0;
            r_step      <= 2'd0;
            r_acc_r     <= '0;
            r_acc_i     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_p         <= '0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_ar       <= a[2*W-1:W];
                        r_ai       <= a[W-1:0];
                        r_br       <= b[2*W-1:W];
                        r_bi       <= b[W-1:0];
                        r_step     <= 2'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    r_step <= r_step + 2'd1;
                    case (r_step)
                        2'd0: r_acc_r <= w_prod_x;
                        2'd1: r_acc_r <= w_diff_r;
                        2'd2: r_acc_i <= w_prod_x;
                        default: begin
                            r_p         <= {w_sat_r[W-1:0], w_sat_i[W-1:0]};
                            r_ovf       <= w_sat_r[W] | w_sat_i[W];
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    endcase
                end
                ST_DONE: begin
                    // The handoff edge never accepts; a waiting operand is taken next cycle.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign p         = r_p;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_complex_mult_seq.sv
// Directed bench for complex_mult_seq (W=8) with a small saturating reference model.
module tb_complex_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    complex_mult_seq #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] sat8(input int v);
        logic [8:0] r;
        if (v > 127)       r = {1'b1, 8'h7F};
        else if (v < -128) r = {1'b1, 8'h80};
        else               r = {1'b0, v[7:0]};
        return r;
    endfunction

    // Returns {ovf, pr, pi}
    function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y);
        int ar, ai, br, bi;
        logic [8:0] sr, si;
        ar = int'($signed(x[15:8]));
        ai = int'($signed(x[7:0]));
        br = int'($signed(y[15:8]));
        bi = int'($signed(y[7:0]));
        sr = sat8(ar * br - ai * bi);
        si = sat8(ar * bi + ai * br);
        return {sr[8] | si[8], sr[7:0], si[7:0]};
    endfunction

    task automatic send_and_get(input logic [15:0] ta, input logic [15:0] tb_v, output logic [16:0] res);
        int n;
        a = ta;
        b = tb_v;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        a = 16'hA5A5;
        b = 16'h5A5A;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        if (!out_valid) chk("timeout_out_valid", 32'd0, 32'd1);
        res = {ovf, p};
        tick();
    endtask

    logic [16:0] res;
    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic [16:0] got;
    logic        fire_in;
    logic        fire_out;
    int          ni;
    int          no;
    int          cyc;
    int          n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0;
        b         = 16'h0;
        repeat (3) tick();
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_p",         32'(p),         32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        rst = 1'b0;
        tick();

        // Test 1: cycle-accurate single operation, {4,2}*{3,6} = {0,30}
        a = 16'h0402;
        b = 16'h0306;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 16'hFFFF;
        b = 16'h8080;
        chk("t1_in_ready_drop", 32'(in_ready), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("t1_no_valid_e%0d", i), 32'(out_valid), 32'd0);
        end
        tick();
        chk("t1_valid_e4",    32'(out_valid), 32'd1);
        chk("t1_p",           32'(p),         32'h001E);
        chk("t1_ovf",         32'(ovf),       32'd0);
        chk("t1_in_ready_e4", 32'(in_ready),  32'd0);
        tick();
        chk("t1_valid_clear", 32'(out_valid), 32'd0);
        chk("t1_in_ready_e5", 32'(in_ready),  32'd1);

        // Test 2: positive and negative saturation of the real part
        send_and_get(16'h6400, 16'h0200, res);
        chk("t2_pos_sat", 32'(res), 32'h17F00);
        send_and_get(16'h9C00, 16'h0200, res);
        chk("t2_neg_sat", 32'(res), 32'h18000);

        // Test 3: full-range corner, acc_i = +32768 must clamp to +127
        send_and_get(16'h8080, 16'h8080, res);
        chk("t3_corner", 32'(res), 32'h1007F);

        // Test 4: backpressure with a second pair waiting
        a = 16'h0101;
        b = 16'h01FF;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        a = 16'h0300;
        b = 16'h0200;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("t4_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("t4_hold_valid%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("t4_hold_p%0d", i),     32'(p),         32'h0200);
            chk($sformatf("t4_hold_rdy%0d", i),   32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("t4_handoff_valid", 32'(out_valid), 32'd0);
        chk("t4_handoff_rdy",   32'(in_ready),  32'd1);
        tick();
        chk("t4_second_accepted", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        repeat (3) tick();
        chk("t4_second_not_yet", 32'(out_valid), 32'd0);
        tick();
        chk("t4_second_valid", 32'(out_valid), 32'd1);
        chk("t4_second_p",     32'({ovf, p}),  32'h00600);
        tick();

        // Test 5: reset in the middle of the multiply steps
        a = 16'h0505;
        b = 16'h0505;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("t5_rdy",   32'(in_ready),  32'd1);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_p",     32'(p),         32'd0);
        chk("t5_ovf",   32'(ovf),       32'd0);
        rst = 1'b0;
        send_and_get(16'h0203, 16'h04FF, res);
        chk("t5_after", 32'(res), 32'h00B0A);

        // Test 6: streamed random pairs with random out_ready
        for (int i = 0; i < 8; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 16'($urandom);
        end
        ni  = 0;
        no  = 0;
        cyc = 0;
        while (no < 8 && cyc < 1000) begin
            in_valid = (ni < 8);
            if (ni < 8) begin
                a = va[ni];
                b = vb[ni];
            end
            out_ready = 1'($urandom_range(0, 1));
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            got      = {ovf, p};
            tick();
            cyc++;
            if (fire_in) ni++;
            if (fire_out) begin
                chk($sformatf("t6_result%0d", no), 32'(got), 32'(model(va[no], vb[no])));
                no++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t6_out_count", 32'(no), 32'd8);
        chk("t6_in_count",  32'(ni), 32'd8);
        repeat (8) tick();
        chk("t6_no_extra", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
